// File: rtl/bram_pkg.sv
// Shared constants and parameter-derivation helpers for the BRAM request
// controller and its response queue.
package bram_pkg;

  // Number of responses that can be outstanding (queued plus in flight).
  localparam int RSP_FIFO_DEPTH = 3;

  // Word-address width for a BRAM of the given depth (never below 1 bit).
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Write-enable width: one bit per byte lane in byte mode, else a single bit.
  function automatic int calc_we_w(input int width, input int write_byte);
    return (write_byte != 0) ? (width / 8) : 1;
  endfunction

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int calc_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Small in-order response queue. Pointers wrap modulo DEPTH, which need not
// be a power of two. A simultaneous push and pop leaves the count unchanged.
module bram_rsp_fifo
  import bram_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = RSP_FIFO_DEPTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = calc_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : (ptr + PW'(1));
  endfunction

  assign empty     = (count == '0);
  assign do_push   = push && (count != CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign head_data = slots[rd_ptr];

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_ctrl.sv
// Valid/ready request front end for a single-port BRAM with one cycle of
// read latency. Requests drive the BRAM port combinationally in the accept
// cycle; the BRAM output is captured one cycle later into a 3-entry response
// queue. Ready depends only on registered occupancy, so there is no
// combinational path from rsp_ready or req_valid to req_ready.
module bram_ctrl
  import bram_pkg::*;
#(
  parameter int DEPTH      = 65536,
  parameter int WIDTH      = 32,
  parameter int WRITE_BYTE = 0,
  localparam int AW   = calc_aw(DEPTH),
  localparam int NB   = WIDTH / 8,
  localparam int WE_W = calc_we_w(WIDTH, WRITE_BYTE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [NB-1:0]    req_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_din,
  output logic [WE_W-1:0]  mem_we,
  input  logic [WIDTH-1:0] mem_dout
);

  localparam int CW = calc_cw(RSP_FIFO_DEPTH);
  localparam int OW = CW + 1;

  logic             accept;
  logic             inflight;
  logic             inflight_write;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] din_q;
  logic [WE_W-1:0]  we_bits;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [OW-1:0]    occupancy;
  logic [WIDTH-1:0] rsp_data_in;
  logic [WIDTH:0]   push_data;
  logic [WIDTH:0]   head_data;
  logic             pop;

  // Occupancy counts the response already captured plus the one whose BRAM
  // read is still in flight; both will need a queue slot.
  assign occupancy = {1'b0, fifo_count} + OW'(inflight);
  assign req_ready = !rst && (occupancy < OW'(RSP_FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  if (WRITE_BYTE != 0) begin : g_byte_we
    assign we_bits = req_wstrb;
  end else begin : g_word_we
    assign we_bits = |req_wstrb;
  end

  // Reset forces the port to zero; otherwise address and data hold the last
  // accepted request so the BRAM sees a quiet, stable port when idle.
  assign mem_we   = (accept && req_write) ? we_bits : '0;
  assign mem_addr = rst ? '0 : (accept ? req_addr : addr_q);
  assign mem_din  = rst ? '0 : (accept ? req_wdata : din_q);

  // Remember the last driven address/data for idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      din_q  <= '0;
    end else if (accept) begin
      addr_q <= req_addr;
      din_q  <= req_wdata;
    end
  end

  // One-cycle tag marking that mem_dout belongs to last cycle's request.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight       <= 1'b0;
      inflight_write <= 1'b0;
    end else begin
      inflight       <= accept;
      inflight_write <= accept && req_write;
    end
  end

  // Write responses carry zero data; reads capture the BRAM output.
  assign rsp_data_in = inflight_write ? '0 : mem_dout;
  assign push_data   = {inflight_write, rsp_data_in};
  assign pop         = rsp_valid && rsp_ready;

  bram_rsp_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Reset hides the queue immediately, before its state clears at the edge.
  assign rsp_valid = !rst && !fifo_empty;
  assign rsp_write = rsp_valid && head_data[WIDTH];
  assign rsp_rdata = rsp_valid ? head_data[WIDTH-1:0] : '0;

endmodule

// File: doc/bram_ctrl.md
BRAM_CTRL -- requirements
Module: bram_ctrl

Interface
REQ-001 SHALL have parameters, one per line: DEPTH, 65536, words in attached bram; WIDTH, 32, data bits; WRITE_BYTE, 0, 1 = byte-granular write enables.
REQ-002 SHALL derive AW = $clog2(DEPTH), NB = WIDTH/8, WE_W = WRITE_BYTE ? NB : 1.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when valid&&ready.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  AW  word address.
REQ-009 req_wdata  input  WIDTH  write data.
REQ-010 req_wstrb  input  NB  byte strobes.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  response consumed when valid&&ready.
REQ-013 rsp_write  output  1  response belongs to a write.
REQ-014 rsp_rdata  output  WIDTH  read data; 0 for writes.
REQ-015 mem_addr  output  AW, mem_din  output  WIDTH, mem_we  output  WE_W, mem_dout  input  WIDTH: bram port; bram registers addr/din/we and returns data one cycle after presentation.

Function
- REQ-016 On accept in cycle N, SHALL drive mem_addr=req_addr, mem_din=req_wdata combinationally in cycle N.
- REQ-017 mem_we SHALL be req_wstrb (WRITE_BYTE=1) or |req_wstrb (WRITE_BYTE=0) on an accepted write; 0 otherwise, including reads and idle cycles.
- REQ-018 When no request is accepted, mem_addr SHALL hold its last driven value.
- REQ-019 SHALL set an inflight flag for the cycle after acceptance (N+1) and record req_write.
- REQ-020 In cycle N+1, SHALL push {write flag, write ? 0 : mem_dout} into a 3-entry in-order response FIFO.
- REQ-021 rsp_valid SHALL be high from cycle N+2 at the earliest, so minimum request-to-response latency is 2 cycles.
- REQ-022 Response order SHALL equal request order; exactly one response per accepted request.
- REQ-023 req_ready = (fifo_count + inflight) < 3, registered-state only, with no combinational path from rsp_ready or req_valid.
- REQ-024 With rsp_ready held high, SHALL sustain one request per cycle indefinitely.
- REQ-025 Full FIFO: rsp_valid/rsp_write/rsp_rdata SHALL hold stable until popped.
- REQ-026 Simultaneous push and pop in one cycle SHALL leave the count unchanged; pointers wrap modulo 3.
- REQ-027 Read immediately after a write to the same address SHALL return the new data; the bram's write-then-read timing guarantees this, and no forwarding logic is permitted.
- REQ-028 req_wstrb = 0 on a write SHALL still produce a response, with mem_we = 0.

Reset
- REQ-029 While rst is high: req_ready=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_din=0; FIFO count, pointers, and inflight cleared.
- REQ-030 Reset mid-operation SHALL discard all queued and inflight responses.
- REQ-031 A write presented in the cycle before rst still commits inside the bram; this is accepted behaviour.
- REQ-032 Nothing SHALL be accepted in the cycle rst is high; req_ready rises the cycle after rst falls.

Structure
- REQ-033 Shared package bram_pkg SHALL hold RSP_FIFO_DEPTH=3 and the AW/WE_W derivation functions.
- REQ-034 The response queue SHALL be sub-module bram_rsp_fifo (parameter WIDTH+1, depth 3, count output); the remaining logic is flat.

Verification
- REQ-035 Write addr 0x10 data 0xDEADBEEF strb 0xF, then read 0x10 next cycle -> mem_we=1 (word mode), read response 0xDEADBEEF at cycle N+3.
- REQ-036 WRITE_BYTE=1: write 0x11223344 to 0x20, then strb 0x2 data 0x0000AA00 -> read returns 0x1122AA44.
- REQ-037 rsp_ready=0, issue 5 reads -> exactly 3 accepted, req_ready low after the third; release -> in-order data, remaining 2 accepted.
- REQ-038 rsp_ready=1, 100 back-to-back reads of addrs 0..99 preloaded with addr*3 -> one response per cycle, values addr*3, no bubbles after the first 2 cycles.
- REQ-039 Assert rst with FIFO holding 2 entries and one inflight -> rsp_valid=0 next cycle, no stale response after release.
- REQ-040 Read DEPTH-1 then 0 -> correct data for both, no address wrap error.
